// File: rtl/mips32_fetch_queue.sv
// -----------------------------------------------------------------------------
// mips32_fetch_queue
//
// Instruction-fetch front end for the MIPS32 pipeline, sitting directly
// upstream of ID. A word-addressed PC issues in-order requests to
// instruction memory (req/gnt, responses flagged by rvalid). Returned words
// are buffered together with their NPC in a DEPTH-entry circular queue that
// feeds ID over valid/ready. A branch redirect flushes the queue and marks
// every fetch still in flight to be dropped when it returns.
//
// Ports
//   clk1            in   single clock, all state updates on posedge
//   rst             in   synchronous active-high reset
//   halt            in   stop issuing new fetches (queue still drains)
//   redirect_valid  in   restart fetch at redirect_pc
//   redirect_pc     in   branch target (word address)
//   imem_req        out  fetch request
//   imem_addr       out  request word address, low AW bits of pc
//   imem_gnt        in   request accepted when imem_req && imem_gnt
//   imem_rvalid     in   read data valid, in request order
//   imem_rdata      in   instruction word
//   id_valid        out  queue head valid for ID
//   id_ready        in   ID consumes head on id_valid && id_ready
//   id_ir           out  head instruction
//   id_npc          out  head instruction address + 1
//   occupancy       out  current queue entry count
// -----------------------------------------------------------------------------
module mips32_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          AW       = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk1,
    input  logic                     rst,
    input  logic                     halt,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     imem_req,
    output logic [AW-1:0]            imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [31:0]              imem_rdata,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [31:0]              id_ir,
    output logic [31:0]              id_npc,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] LP_DEPTH = DEPTH[CW:0];

    logic [31:0]   r_pc;
    logic [31:0]   r_resp_pc;
    logic [31:0]   r_ir_mem  [DEPTH];
    logic [31:0]   r_npc_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop;

    logic [CW:0]   w_credit_used;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_drop_hit;
    logic          w_nonempty;

    // Queued entries plus outstanding fetches (including ones that will be
    // dropped) may never exceed DEPTH, so a returning word always has a slot.
    always_comb begin
        w_credit_used = {1'b0, r_count} + {1'b0, r_inflight};
        imem_req      = !rst && !halt && !redirect_valid && (w_credit_used < LP_DEPTH);
        imem_addr     = r_pc[AW-1:0];
        w_accept      = imem_req && imem_gnt;
        w_drop_hit    = imem_rvalid && (r_drop != '0);
        w_push        = imem_rvalid && (r_drop == '0) && !redirect_valid && !rst;
        w_nonempty    = (r_count != '0);
        id_valid      = w_nonempty && !redirect_valid;
        w_pop         = id_valid && id_ready;
        id_ir         = w_nonempty ? r_ir_mem[r_head]  : 32'h0;
        id_npc        = w_nonempty ? r_npc_mem[r_head] : 32'h0;
        occupancy     = r_count;
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
        end else if (redirect_valid) begin
            // No request is issued in a redirect cycle, so every fetch still
            // outstanding after this edge belongs to the old path.
            r_pc       <= redirect_pc;
            r_resp_pc  <= redirect_pc;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_inflight <= r_inflight - CW'(imem_rvalid);
            r_drop     <= r_inflight - CW'(imem_rvalid);
        end else begin
            if (w_accept) begin
                r_pc <= r_pc + 32'd1;
            end
            r_inflight <= r_inflight + CW'(w_accept) - CW'(imem_rvalid);
            if (w_drop_hit) begin
                r_drop <= r_drop - CW'(1);
            end
            if (w_push) begin
                r_tail    <= r_tail + PW'(1);
                r_resp_pc <= r_resp_pc + 32'd1;
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage needs no reset: r_count gates visibility of every slot.
    always_ff @(posedge clk1) begin
        if (w_push) begin
            r_ir_mem[r_tail]  <= imem_rdata;
            r_npc_mem[r_tail] <= r_resp_pc + 32'd1;
        end
    end

endmodule

// File: tb/tb_mips32_fetch_queue.sv
module tb_mips32_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam int          AW       = 10;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic                   clk1;
    logic                   rst;
    logic                   halt;
    logic                   redirect_valid;
    logic [31:0]            redirect_pc;
    logic                   imem_req;
    logic [AW-1:0]          imem_addr;
    logic                   imem_gnt;
    logic                   imem_rvalid;
    logic [31:0]            imem_rdata;
    logic                   id_valid;
    logic                   id_ready;
    logic [31:0]            id_ir;
    logic [31:0]            id_npc;
    logic [$clog2(DEPTH):0] occupancy;

    mips32_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(RESET_PC)) dut (
        .clk1           (clk1),
        .rst            (rst),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_ir          (id_ir),
        .id_npc         (id_npc),
        .occupancy      (occupancy)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] npc;
    } ent_t;

    // Reference model: what ID should see, stated as fetched-address facts.
    pend_t       pend[$];
    ent_t        model_q[$];
    logic [31:0] mpc;
    int          epoch;
    int          cyc;
    int          lat;
    int          last_due;
    int          errors;
    int          checks;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h100 + 32'(a[AW-1:0]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle, entered and left at a negedge with inputs already set.
    task automatic cycle();
        bit    rv;
        bit    push_new;
        bit    exp_req;
        bit    exp_idv;
        bit    acc;
        bit    pop;
        int    nd;
        pend_t pr;
        rv = 1'b0;
        push_new = 1'b0;
        exp_idv = 1'b0;
        if (!rst && pend.size() > 0 && pend[0].due <= cyc) rv = 1'b1;
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_word(pend[0].addr) : 32'hDEAD_BEEF;
        #1;
        exp_req = !rst && !halt && !redirect_valid && ((model_q.size() + pend.size()) < DEPTH);
        check("imem_req", imem_req, exp_req);
        if (!rst) begin
            if (exp_req) check("imem_addr", imem_addr, mpc[AW-1:0]);
            exp_idv = (model_q.size() != 0) && !redirect_valid;
            check("id_valid", id_valid, exp_idv);
            check("occupancy", occupancy, 32'(model_q.size()));
            if (exp_idv) begin
                check("id_ir", id_ir, model_q[0].ir);
                check("id_npc", id_npc, model_q[0].npc);
            end
        end
        acc = exp_req && imem_gnt;
        pop = exp_idv && id_ready;
        if (rst) begin
            model_q.delete();
            pend.delete();
            mpc = RESET_PC;
            epoch++;
            last_due = 0;
        end else begin
            if (rv) begin
                pr = pend.pop_front();
                if (!redirect_valid && pr.epoch == epoch) push_new = 1'b1;
            end
            if (redirect_valid) begin
                model_q.delete();
                mpc = redirect_pc;
                epoch++;
            end else begin
                if (pop) void'(model_q.pop_front());
                if (push_new) model_q.push_back('{ir: mem_word(pr.addr), npc: pr.addr + 32'd1});
                if (acc) begin
                    nd = cyc + lat;
                    if (nd <= last_due) nd = last_due + 1;
                    last_due = nd;
                    pend.push_back('{addr: mpc, epoch: epoch, due: nd});
                    mpc = mpc + 32'd1;
                end
            end
        end
        @(posedge clk1);
        cyc++;
        @(negedge clk1);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        halt = 1'b0;
        redirect_valid = 1'b0;
        repeat (n) cycle();
        rst = 1'b0;
        #1;
        check("rst_id_valid", id_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_id_ir", id_ir, 0);
        check("rst_id_npc", id_npc, 0);
        check("rst_imem_addr", imem_addr, RESET_PC[AW-1:0]);
    endtask

    int cnt;
    bit seen;

    initial begin
        errors = 0; checks = 0; cyc = 0; epoch = 0; lat = 1; last_due = 0;
        mpc = RESET_PC;
        rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0; id_ready = 1'b1;
        @(negedge clk1);

        // T1: back-to-back stream, first id_valid two cycles after reset release
        lat = 1; imem_gnt = 1'b1; id_ready = 1'b1;
        do_reset(2);
        cycle(); cycle();
        check("t1_first_valid", id_valid, 1);
        check("t1_first_ir", id_ir, 32'h100);
        check("t1_first_npc", id_npc, 32'h1);
        repeat (8) cycle();
        check("t1_ir_8", id_ir, 32'h108);
        check("t1_npc_8", id_npc, 32'h9);

        // T2: ID stalled: exactly DEPTH accepts, then drain in order
        id_ready = 1'b0;
        do_reset(1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req && imem_gnt) cnt++;
            cycle();
        end
        check("t2_accepts", cnt, 4);
        check("t2_occupancy", occupancy, 4);
        check("t2_req_off", imem_req, 0);
        id_ready = 1'b1;
        repeat (8) cycle();

        // T3: redirect with two fetches in flight on a 3-cycle memory
        lat = 3;
        do_reset(1);
        cycle(); cycle();
        check("t3_inflight", 32'(pend.size()), 2);
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        cycle();
        redirect_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (id_valid) begin seen = 1'b1; break; end
            cycle();
        end
        check("t3_seen", seen, 1);
        check("t3_ir", id_ir, 32'h120);
        check("t3_npc", id_npc, 32'h21);
        repeat (6) cycle();

        // T4: halt with three entries queued
        lat = 1; id_ready = 1'b0;
        do_reset(1);
        repeat (3) cycle();
        halt = 1'b1;
        repeat (3) cycle();
        check("t4_occupancy", occupancy, 3);
        check("t4_no_req", imem_req, 0);
        id_ready = 1'b1;
        repeat (5) cycle();
        check("t4_drained_valid", id_valid, 0);
        check("t4_drained_occ", occupancy, 0);
        halt = 1'b0;
        #1;
        check("t4_resume_req", imem_req, 1);
        check("t4_resume_addr", imem_addr, 3);
        repeat (6) cycle();

        // T5: grant withheld at address 7
        do_reset(1);
        for (int i = 0; i < 20; i++) begin
            if (mpc == 32'd7) break;
            cycle();
        end
        imem_gnt = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("t5_req_held", imem_req, 1);
            check("t5_addr_held", imem_addr, 7);
            cycle();
        end
        imem_gnt = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (id_valid && id_ready && id_ir == 32'h107) cnt++;
            cycle();
        end
        check("t5_once", cnt, 1);

        // T6: reset with a full-ish queue and responses pending
        lat = 2; id_ready = 1'b0;
        do_reset(1);
        repeat (6) cycle();
        check("t6_occ_before", occupancy, 4);
        do_reset(1);
        lat = 1; id_ready = 1'b1;
        repeat (4) cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        cycle();
        redirect_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (id_valid) begin seen = 1'b1; break; end
            cycle();
        end
        check("t6_seen", seen, 1);
        check("t6_ir", id_ir, 32'h140);
        check("t6_npc", id_npc, 32'h41);

        // 32-bit wrap of pc / npc
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        cycle();
        redirect_valid = 1'b0;
        repeat (10) cycle();

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) lat = $urandom_range(1, 3);
            halt           = ($urandom_range(0, 9) == 0);
            redirect_valid = ($urandom_range(0, 14) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                         : $urandom;
            id_ready       = ($urandom_range(0, 3) != 0);
            imem_gnt       = ($urandom_range(0, 3) != 0);
            cycle();
        end
        halt = 1'b0; redirect_valid = 1'b0; id_ready = 1'b1; imem_gnt = 1'b1;
        repeat (10) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
